// File: rtl/nn_infer_sched_pkg.sv
// Shared constants, state encodings and the output clamp for the 9-2-9 inference sequencer.
package nn_pkg;

    localparam int N_IN  = 9;
    localparam int N_OUT = 9;
    localparam int W     = 20;

    localparam logic signed [W-1:0] ONE = 20'sh10000;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HID  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // One row of the output-neuron ROM selected by dp_sel.
    typedef struct packed {
        logic signed [W-1:0] wn_1;
        logic signed [W-1:0] wn_2;
        logic signed [W-1:0] b_neuron;
    } wrom_entry_t;

    function automatic logic signed [W-1:0] clamp_unit(input logic signed [W-1:0] v);
        if (v < 0)
            return '0;
        else if (v > ONE)
            return ONE;
        else
            return v;
    endfunction

endpackage

// File: rtl/nn_infer_sched_if.sv
// Input-vector and output-frame handshakes of the inference sequencer.
interface nn_infer_sched_if;
    import nn_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [N_IN-1:0]      x;
    logic                 out_valid;
    logic                 out_ready;
    logic [N_OUT*W-1:0]   y_flat;

    modport master (
        output in_valid, x, out_ready,
        input  in_ready, out_valid, y_flat
    );

    modport slave (
        input  in_valid, x, out_ready,
        output in_ready, out_valid, y_flat
    );

endinterface

// File: rtl/nn_infer_sched_ybank.sv
// Result bank: clamps the shared sigmoid output into slot cap_idx and tracks range errors.
module nn_infer_sched_ybank
    import nn_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cap_en,
    input  logic [3:0]            cap_idx,
    input  logic signed [W-1:0]   dp_sig,
    input  logic                  clr_err,
    output logic [N_OUT*W-1:0]    y_flat,
    output logic                  range_err
);

    logic signed [W-1:0] y_q [N_OUT];
    logic signed [W-1:0] y_d [N_OUT];
    logic                range_err_q, range_err_d;
    logic signed [W-1:0] sig_clamped;

    assign sig_clamped = clamp_unit(dp_sig);

    always_comb begin
        y_d = y_q;
        range_err_d = range_err_q;
        if (clr_err)
            range_err_d = 1'b0;
        if (cap_en) begin
            y_d[cap_idx] = sig_clamped;
            if (sig_clamped != dp_sig)
                range_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_OUT; k++)
                y_q[k] <= '0;
            range_err_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            range_err_q <= range_err_d;
        end
    end

    always_comb begin
        y_flat = '0;
        for (int k = 0; k < N_OUT; k++)
            y_flat[k*W +: W] = y_q[k];
    end

    assign range_err = range_err_q;

endmodule

// File: rtl/nn_infer_sched.sv
// Sequencer for one inference: latch X, let the hidden layer settle, then walk the
// shared output neuron through indices 0..N_OUT-1 and present the clamped frame.
//   state  | meaning
//   S_IDLE | ready for a new X
//   S_HID  | X held, hidden layer settling
//   S_OUT  | stepping dp_sel through output slots, capturing on each slot's last cycle
//   S_DONE | frame valid, waiting for out_ready
module nn_infer_sched
    import nn_pkg::*;
#(
    parameter int HID_CYCLES = 4,
    parameter int OUT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nn_infer_sched_if.slave       bus,
    output logic [N_IN-1:0]       dp_x,
    output logic [3:0]            dp_sel,
    input  logic signed [W-1:0]   dp_sig,
    output logic                  range_err,
    output logic                  busy
);

    localparam int MAX_CYC = (HID_CYCLES > OUT_CYCLES) ? HID_CYCLES : OUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [3:0]        sel_q, sel_d;
    logic [N_IN-1:0]   dp_x_q, dp_x_d;
    logic              cap_en;
    logic              accept;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        sel_d      = sel_q;
        dp_x_d     = dp_x_q;
        cap_en     = 1'b0;
        accept     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    dp_x_d     = bus.x;
                    wait_cnt_d = '0;
                    state_d    = S_HID;
                end
            end
            S_HID: begin
                if (wait_cnt_q == CNT_W'(HID_CYCLES - 1)) begin
                    sel_d      = '0;
                    wait_cnt_d = '0;
                    state_d    = S_OUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_OUT: begin
                if (wait_cnt_q == CNT_W'(OUT_CYCLES - 1)) begin
                    cap_en = 1'b1;
                    if (sel_q == 4'(N_OUT - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        sel_d      = sel_q + 4'd1;
                        wait_cnt_d = '0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            sel_q      <= '0;
            dp_x_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            sel_q      <= sel_d;
            dp_x_q     <= dp_x_d;
        end
    end

    nn_infer_sched_ybank u_ybank (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap_en    (cap_en),
        .cap_idx   (sel_q),
        .dp_sig    (dp_sig),
        .clr_err   (accept),
        .y_flat    (bus.y_flat),
        .range_err (range_err)
    );

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign busy          = (state_q != S_IDLE);
    assign dp_x          = dp_x_q;
    assign dp_sel        = sel_q;

endmodule
